// File: rtl/hazard_scoreboard.sv
// Hazard detection and forwarding-select unit for the in-order pipeline.
// A shift-register scoreboard tracks the destination of each in-flight
// instruction, one entry per downstream stage (entry 0 = EX). Stall and
// forwarding selects are combinational from that scoreboard and the
// decoding instruction's sources.
module hazard_scoreboard #(
    parameter int REG_W  = 5,
    parameter int DEPTH  = 3,
    parameter int FWD_EN = 0,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_we,
    input  logic [REG_W-1:0] id_ws,
    input  logic             id_is_load,
    input  logic             flush,
    output logic             stall,
    output logic [3:0]       fwd_rs_sel,
    output logic [3:0]       fwd_rt_sel,
    output logic [CNT_W-1:0] stall_count
);

    logic [DEPTH-1:0] sb_v;
    logic [DEPTH-1:0] sb_ld;
    logic [REG_W-1:0] sb_ws [DEPTH];
    logic [DEPTH-1:0] hit_rs;
    logic [DEPTH-1:0] hit_rt;
    logic             enter;

    // Per-entry source match; register 0 is hardwired and never matches
    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            hit_rs[k] = id_use_rs && (id_rs != '0) && sb_v[k] && (sb_ws[k] == id_rs);
            hit_rt[k] = id_use_rt && (id_rt != '0) && sb_v[k] && (sb_ws[k] == id_rt);
        end
    end

    // Interlock mode stalls on any match; forwarding mode only on load-use in EX
    always_comb begin
        if (FWD_EN != 0) begin
            stall = id_valid && !flush && sb_ld[0] && (hit_rs[0] || hit_rt[0]);
        end else begin
            stall = id_valid && !flush && ((|hit_rs) || (|hit_rt));
        end
    end

    // Forwarding select: first hit scanning from entry 0 is the youngest producer
    always_comb begin
        fwd_rs_sel = '0;
        fwd_rt_sel = '0;
        if ((FWD_EN != 0) && id_valid && !stall) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (hit_rs[k] && (fwd_rs_sel == '0)) fwd_rs_sel = 4'(k + 1);
                if (hit_rt[k] && (fwd_rt_sel == '0)) fwd_rt_sel = 4'(k + 1);
            end
        end
    end

    // A stalled or squashed instruction is not recorded; a bubble enters instead
    always_comb begin
        enter = id_valid && id_we && !stall && !flush;
    end

    // Scoreboard shift: older entries always advance, new entry lands in EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_v  <= '0;
            sb_ld <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                sb_ws[k] <= '0;
            end
        end else begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                sb_v[k]  <= sb_v[k-1];
                sb_ld[k] <= sb_ld[k-1];
                sb_ws[k] <= sb_ws[k-1];
            end
            sb_v[0]  <= enter;
            sb_ld[0] <= enter && id_is_load;
            sb_ws[0] <= enter ? id_ws : '0;
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: three instances (interlock, forwarding, 4-bit-counter
// interlock) share one decode stream; a queue-based reference model of the
// in-flight instructions predicts each instance's outputs per cycle.
module tb_hazard_scoreboard;

    localparam int D = 3;
    localparam bit MFWD [3] = '{1'b0, 1'b1, 1'b0};
    localparam int CMAX [3] = '{65535, 65535, 15};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid, id_use_rs, id_use_rt, id_we, id_is_load, flush;
    logic [4:0] id_rs, id_rt, id_ws;
    logic       stl [3];
    logic [3:0] fs [3];
    logic [3:0] ft [3];
    logic [15:0] cnt0, cnt1;
    logic [3:0]  cnt2;

    int total = 0;
    int bad = 0;

    hazard_scoreboard #(.REG_W(5), .DEPTH(D), .FWD_EN(0), .CNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_we(id_we), .id_ws(id_ws),
        .id_is_load(id_is_load), .flush(flush), .stall(stl[0]), .fwd_rs_sel(fs[0]),
        .fwd_rt_sel(ft[0]), .stall_count(cnt0));

    hazard_scoreboard #(.REG_W(5), .DEPTH(D), .FWD_EN(1), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_we(id_we), .id_ws(id_ws),
        .id_is_load(id_is_load), .flush(flush), .stall(stl[1]), .fwd_rs_sel(fs[1]),
        .fwd_rt_sel(ft[1]), .stall_count(cnt1));

    hazard_scoreboard #(.REG_W(5), .DEPTH(D), .FWD_EN(0), .CNT_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_we(id_we), .id_ws(id_ws),
        .id_is_load(id_is_load), .flush(flush), .stall(stl[2]), .fwd_rs_sel(fs[2]),
        .fwd_rt_sel(ft[2]), .stall_count(cnt2));

    always #10 clk = ~clk;

    typedef struct packed {
        bit       v;
        bit [4:0] ws;
        bit       ld;
    } ent_t;

    typedef struct {
        int inst;
        int st;
        int fs;
        int ft;
        int cnt;
    } exp_t;

    // in-flight instructions, youngest first
    ent_t sbm [3][$];
    int   mcnt [3];
    exp_t expq [$];

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) begin
            sbm[i].delete();
            for (int k = 0; k < D; k++) sbm[i].push_back('0);
            mcnt[i] = 0;
        end
    endfunction

    function automatic void model_eval(input int i, output int s, output int f1, output int f2);
        int ir = -1;
        int it = -1;
        bit sb;
        for (int k = 0; k < sbm[i].size(); k++) begin
            if (ir < 0 && id_use_rs && id_rs != 0 && sbm[i][k].v && sbm[i][k].ws == id_rs) ir = k;
            if (it < 0 && id_use_rt && id_rt != 0 && sbm[i][k].v && sbm[i][k].ws == id_rt) it = k;
        end
        if (MFWD[i]) sb = id_valid && !flush && (ir == 0 || it == 0) && sbm[i][0].ld;
        else         sb = id_valid && !flush && (ir >= 0 || it >= 0);
        s  = sb ? 1 : 0;
        f1 = (MFWD[i] && id_valid && !sb && ir >= 0) ? ir + 1 : 0;
        f2 = (MFWD[i] && id_valid && !sb && it >= 0) ? it + 1 : 0;
    endfunction

    task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                         input bit we, input int ws, input bit ld, input bit fl);
        int   s, f1, f2;
        exp_t e;
        ent_t n;
        @(negedge clk);
        id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs; id_use_rt = urt;
        id_we = we; id_ws = 5'(ws); id_is_load = ld; flush = fl;
        for (int i = 0; i < 3; i++) begin
            model_eval(i, s, f1, f2);
            e.inst = i; e.st = s; e.fs = f1; e.ft = f2; e.cnt = mcnt[i];
            expq.push_back(e);
            if (rst_n) begin
                n = '0;
                if (v && we && s == 0 && !fl) n = '{1'b1, 5'(ws), ld};
                sbm[i].push_front(n);
                void'(sbm[i].pop_back());
                if (s != 0 && mcnt[i] < CMAX[i]) mcnt[i]++;
            end
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rnd();
        drive($urandom_range(0, 9) > 1, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 3), $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
    endtask

    task automatic rst_tail();
        repeat (2) rnd();
        @(negedge clk);
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_we = 0; id_ws = 0; id_is_load = 0; flush = 0;
        rst_n = 1'b1;
    endtask

    task automatic rst_seq();
        idle();
        #4;
        rst_n = 1'b0;
        model_clear();
        rst_tail();
    endtask

    // Monitor: outputs are combinational every cycle, checked mid-low-phase
    initial begin
        exp_t e;
        int   a_st, a_fs, a_ft, a_c;
        forever begin
            @(negedge clk);
            #2;
            while (expq.size() > 0) begin
                e = expq.pop_front();
                a_st = int'(stl[e.inst]);
                a_fs = int'(fs[e.inst]);
                a_ft = int'(ft[e.inst]);
                case (e.inst)
                    0:       a_c = int'(cnt0);
                    1:       a_c = int'(cnt1);
                    default: a_c = int'(cnt2);
                endcase
                chk($sformatf("sb_stall%0d", e.inst), a_st, e.st);
                chk($sformatf("sb_fwdrs%0d", e.inst), a_fs, e.fs);
                chk($sformatf("sb_fwdrt%0d", e.inst), a_ft, e.ft);
                chk($sformatf("sb_count%0d", e.inst), a_c, e.cnt);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_we = 0; id_ws = 0; id_is_load = 0; flush = 0;
        model_clear();

        // reset held with arbitrary inputs
        rnd(); rnd();
        drive(1, 5, 5, 1, 1, 1, 5, 1, 0);
        #3 chk("rst_hold_stall", int'(stl[0]), 0);
        chk("rst_hold_cnt", int'(cnt0), 0);
        rst_tail();
        idle();
        #3 chk("rst_rel_stall", int'(stl[1]), 0);
        chk("rst_rel_fwd", int'(fs[1]), 0);
        chk("rst_rel_cnt", int'(cnt2), 0);

        // interlock: add $5 then a reader of $5
        rst_seq();
        drive(1, 0, 0, 0, 0, 1, 5, 0, 0);
        for (int c = 1; c <= 3; c++) begin
            drive(1, 5, 0, 1, 0, 1, 6, 0, 0);
            #3 chk($sformatf("il_stall_c%0d", c), int'(stl[0]), 1);
            if (c == 1) begin
                chk("fw_alu_stall", int'(stl[1]), 0);
                chk("fw_alu_sel", int'(fs[1]), 1);
            end
        end
        drive(1, 5, 0, 1, 0, 1, 6, 0, 0);
        #3 chk("il_stall_c4", int'(stl[0]), 0);
        chk("il_count", int'(cnt0), 3);

        // writer of $0 never matches
        rst_seq();
        drive(1, 0, 0, 0, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 1, 1, 1, 7, 0, 0);
        #3 chk("r0_stall_il", int'(stl[0]), 0);
        chk("r0_stall_fw", int'(stl[1]), 0);

        // load-use in forwarding mode
        rst_seq();
        drive(1, 0, 0, 0, 0, 1, 8, 1, 0);
        drive(1, 0, 8, 0, 1, 1, 9, 0, 0);
        #3 chk("lu_stall", int'(stl[1]), 1);
        chk("lu_sel_held", int'(ft[1]), 0);
        drive(1, 0, 8, 0, 1, 1, 9, 0, 0);
        #3 chk("lu_stall_after", int'(stl[1]), 0);
        chk("lu_fwd_rt", int'(ft[1]), 2);

        // youngest producer wins
        rst_seq();
        drive(1, 0, 0, 0, 0, 1, 3, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 3, 0, 0);
        drive(1, 3, 0, 1, 0, 0, 0, 0, 0);
        #3 chk("young_sel1", int'(fs[1]), 1);
        rst_seq();
        drive(1, 0, 0, 0, 0, 1, 3, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 3, 0, 0);
        idle();
        drive(1, 3, 0, 1, 0, 0, 0, 0, 0);
        #3 chk("young_sel2", int'(fs[1]), 2);

        // flush wins over a match
        rst_seq();
        drive(1, 0, 0, 0, 0, 1, 5, 0, 0);
        drive(1, 5, 0, 1, 0, 1, 6, 0, 1);
        #3 chk("fl_stall", int'(stl[0]), 0);
        idle();
        #3 chk("fl_count", int'(cnt0), 0);
        rst_seq();
        drive(1, 0, 0, 0, 0, 1, 9, 0, 1);
        drive(1, 9, 0, 1, 0, 0, 0, 0, 0);
        #3 chk("fl_squashed", int'(stl[0]), 0);

        // asynchronous reset during a stall
        rst_seq();
        drive(1, 0, 0, 0, 0, 1, 5, 0, 0);
        drive(1, 5, 0, 1, 0, 0, 0, 0, 0);
        #3 chk("ar_pre_stall", int'(stl[0]), 1);
        #1 rst_n = 1'b0;
        model_clear();
        #1 chk("ar_stall_drop", int'(stl[0]), 0);
        rst_tail();

        // counter saturation with CNT_W=4
        rst_seq();
        drive(1, 0, 0, 0, 0, 1, 5, 0, 0);
        repeat (40) drive(1, 5, 0, 1, 0, 1, 5, 0, 0);
        idle();
        #3 chk("sat_cnt4", int'(cnt2), 15);
        chk("sat_cnt16", int'(cnt0), 30);

        // randomized traffic against the model
        rst_seq();
        repeat (400) rnd();
        idle();

        @(negedge clk);
        #5;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard-detection and forwarding-select unit for the in-order MIPS pipeline. It sits beside the decode stage and keeps an internal shift-register scoreboard of in-flight destination registers, one entry per downstream stage. From that scoreboard and the decoding instruction's source registers it raises a same-cycle stall and, in forwarding mode, selects the forwarding source for each operand. It also provides a saturating stall-cycle performance counter.

## Interface
Parameters:
- REG_W, 5, register address width.
- DEPTH, 3, number of tracked stages after decode; entry 0 = EX, entry DEPTH-1 = WB. Legal range 1..8.
- FWD_EN, 0, 0 = interlock-only (stall on any match); 1 = forwarding mode (stall on load-use only).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode holds a real instruction (0 = bubble).
- id_rs, id_rt  in  REG_W  source register numbers.
- id_use_rs, id_use_rt  in  1  the instruction reads rs / rt.
- id_we  in  1  the instruction writes a register.
- id_ws  in  REG_W  destination register.
- id_is_load  in  1  the instruction is a load (lw).
- flush  in  1  squash the decode instruction (taken branch/jump).
- stall  out  1  hold fetch/decode this cycle.
- fwd_rs_sel, fwd_rt_sel  out  4  0 = register file; k+1 = result of scoreboard entry k.
- stall_count  out  CNT_W  saturating count of stalled cycles.

## Operation
- Scoreboard entry k holds {v, ws, ld}. A source "matches" entry k when: the use bit is 1, the source is nonzero, v=1, and ws equals the source. Register 0 never matches.
- FWD_EN=0:
  - stall = id_valid & ~flush & (any match on rs or rt, across all entries).
  - fwd_*_sel are held at 0.
- FWD_EN=1:
  - stall = id_valid & ~flush & (match in entry 0 with ld=1, on rs or rt).
  - fwd_rs_sel = k+1 for the smallest k whose entry matches rs, i.e. the youngest producer wins. Otherwise 0. fwd_rt_sel is determined the same way.
  - Both selects are forced to 0 while stall=1 or id_valid=0.
- Scoreboard shift, every clock:
  - entry[k] <= entry[k-1] for k >= 1.
  - entry[0] <= {1, id_ws, id_is_load} if id_valid & id_we & ~stall & ~flush.
  - Otherwise entry[0] <= bubble {0, 0, 0}.
  - A stalled instruction is not entered, so a bubble enters entry 0 and the older entries keep advancing.
- flush affects only the decode instruction. Entries already in the scoreboard are kept.
- stall_count increments on every clock where stall=1. It saturates at 2^CNT_W-1 and never wraps.

## Timing
- stall and fwd_*_sel are combinational from the registered scoreboard and the current decode inputs. They are valid in the same cycle the inputs are presented. There are no combinational paths from outputs back to inputs.
- Interlock mode, producer followed directly by a dependent instruction: stall lasts DEPTH cycles. The dependent instruction proceeds in the cycle after the producer leaves entry DEPTH-1.
- Forwarding mode, load-use: exactly 1 stall cycle, then fwd_sel = 2 (entry 1, MEM).
- Reset (rst_n=0, asynchronous):
  - All entries cleared to bubble and stall_count = 0.
  - Outputs during and after reset, until a producer enters: stall=0, fwd_*_sel=0, stall_count=0.
  - Reset asserted mid-stall drops stall immediately, in the same cycle, without waiting for a clock edge.
- Simultaneous flush and match: flush wins. stall=0, a bubble enters, and the counter does not increment.
- rs == rt with both used: one match drives both selects identically and contributes a single stall.
- id_we=1 with id_ws=0: the entry is recorded, but it can never match.

## Test plan
- **Reset.** Hold rst_n=0 with arbitrary inputs, then release.
  - Required: stall=0, fwd sels=0, stall_count=0.
  - Then assert rst_n=0 asynchronously during a stall. Required: stall falls before the next clk edge.
- **Interlock, FWD_EN=0, DEPTH=3.** Cycle 0: add $5 (we=1, ws=5). Cycle 1: sub reading rs=5.
  - Required: stall=1 in cycles 1-3 and 0 in cycle 4.
  - Required: stall_count=3.
  - A reader of $0 after a writer with ws=0 must see stall=0.
- **Load-use, FWD_EN=1.** lw ws=8 (is_load=1), then an add reading rt=8.
  - Required: stall=1 for one cycle.
  - Next cycle: stall=0 and fwd_rt_sel=2.
  - A non-load producer followed by a dependent instruction: stall=0 and fwd_sel=1.
- **Youngest-producer priority, FWD_EN=1.** Two consecutive writers of $3, then a reader of rs=3.
  - Required: fwd_rs_sel=1, not 2.
  - Insert one bubble before the reader. Required: fwd_rs_sel=2.
- **Flush.** In FWD_EN=0 mode, assert flush in a cycle that would stall.
  - Required: stall=0 and the counter unchanged.
  - A squashed writer of $9 must not later stall a reader of $9.
- **Counter saturation.** CNT_W=4, hold a stalling condition for 20 cycles (e.g. id_valid=1 with a persistent match, re-injecting producers).
  - Required: stall_count stops at 15 and does not wrap.
